// File: rtl/mem_mon_pkg.sv
// Shared types and constants for the memory-port monitor.
package mem_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    WR_PEND = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        is_write;
  } mem_txn_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

endpackage

// File: rtl/mon_wait_counter.sv
// Saturating pending-cycle counter. `hit` is high on the enabled cycle whose
// increment reaches (or sits at or above) the threshold.
module mon_wait_counter #(
  parameter int CNT_W  = 16,
  parameter int THRESH = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_C    = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = (count == MAX_C) ? count : count + ONE_C;
  assign hit       = en && (count_inc >= THRESH_C);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/mem_port_monitor.sv
// Passive monitor for one CPU memory port: emits registered read/write
// completion records and sticky protocol/timeout flags. MEM_MON_STATS_EN adds stats.
module mem_port_monitor
  import mem_mon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        valid,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic        protocol_error,
  output logic        timeout
);

  // Handshake: a request is held (mem_read or mem_write) until the single
  // cycle where mem_resp is high; that cycle completes it. Read+write together
  // is illegal and is handled as a read.
  logic both_req, any_req, rd_req, wr_req;
  assign both_req = mem_read & mem_write;
  assign any_req  = mem_read | mem_write;
  assign rd_req   = mem_read;
  assign wr_req   = mem_write & ~mem_read;

  mon_state_t  state;
  mem_txn_t    out_q;
  logic [31:0] lat_addr;
  logic [3:0]  lat_mask;
  logic [31:0] lat_data;
  logic        pulse_q;
  logic        perr_q;
  logic        tout_q;

  logic live_mismatch;
  logic cnt_clr, cnt_en, cnt_hit;
  logic rd_done, wr_done;

  assign rd_done = mem_resp && rd_req && (state == IDLE || state == RD_PEND);
  assign wr_done = mem_resp && wr_req && (state == IDLE || state == WR_PEND);

  always_comb begin
    live_mismatch = 1'b0;
    cnt_clr       = 1'b0;
    cnt_en        = 1'b0;
    case (state)
      RD_PEND: begin
        live_mismatch = (mem_address != lat_addr);
        if (rd_req && !mem_resp) cnt_en = 1'b1;
        else                     cnt_clr = 1'b1;
      end
      WR_PEND: begin
        live_mismatch = (mem_address != lat_addr) ||
                        (mem_byte_enable != lat_mask) ||
                        (mem_wdata != lat_data);
        if (wr_req && !mem_resp) cnt_en = 1'b1;
        else                     cnt_clr = 1'b1;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  mon_wait_counter #(
    .CNT_W  (CNT_W),
    .THRESH (TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .hit (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_q    <= '0;
      lat_addr <= '0;
      lat_mask <= '0;
      lat_data <= '0;
      pulse_q  <= 1'b0;
      perr_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      pulse_q <= rd_done | wr_done;
      if (both_req || (mem_resp && !any_req) || live_mismatch) perr_q <= 1'b1;
      if (cnt_hit) tout_q <= 1'b1;

      // Zero-wait completions take live fields; pending ones take the latch.
      if (rd_done) begin
        out_q.addr     <= (state == IDLE) ? mem_address : lat_addr;
        out_q.rdata    <= mem_rdata;
        out_q.is_write <= 1'b0;
      end
      if (wr_done) begin
        out_q.addr     <= (state == IDLE) ? mem_address : lat_addr;
        out_q.wmask    <= (state == IDLE) ? mem_byte_enable : lat_mask;
        out_q.wdata    <= (state == IDLE) ? mem_wdata : lat_data;
        out_q.is_write <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rd_req && !mem_resp) begin
            lat_addr <= mem_address;
            state    <= RD_PEND;
          end else if (wr_req && !mem_resp) begin
            lat_addr <= mem_address;
            lat_mask <= mem_byte_enable;
            lat_data <= mem_wdata;
            state    <= WR_PEND;
          end
        end
        RD_PEND: begin
          if (!rd_req) begin
            perr_q <= 1'b1;
            state  <= IDLE;
          end else if (mem_resp) begin
            state <= IDLE;
          end
        end
        WR_PEND: begin
          if (!wr_req) begin
            perr_q <= 1'b1;
            state  <= IDLE;
          end else if (mem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Both terms are flops, so the pulse decode is glitch-free and one cycle wide.
  assign valid          = pulse_q & ~out_q.is_write;
  assign write          = pulse_q &  out_q.is_write;
  assign addr           = out_q.addr;
  assign rdata          = out_q.rdata;
  assign wmask          = out_q.wmask;
  assign wdata          = out_q.wdata;
  assign protocol_error = perr_q;
  assign timeout        = tout_q;

`ifdef MEM_MON_STATS_EN
  logic [31:0] stat_rd_cnt;
  logic [31:0] stat_wr_cnt;
  logic [31:0] stat_max_lat;
  logic [31:0] pend_lat;
  logic [31:0] cur_lat;
  logic        tout_d;

  assign cur_lat = (state == IDLE) ? 32'd1 : pend_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_cnt  <= '0;
      stat_wr_cnt  <= '0;
      stat_max_lat <= '0;
      pend_lat     <= 32'd2;
      tout_d       <= 1'b0;
    end else begin
      tout_d <= tout_q;
      if (cnt_clr)     pend_lat <= 32'd2;
      else if (cnt_en) pend_lat <= pend_lat + 32'd1;
      if (rd_done) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (wr_done) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if ((rd_done || wr_done) && cur_lat > stat_max_lat) stat_max_lat <= cur_lat;
      if (tout_q && !tout_d)
        $display("mem_port_monitor %m: timeout reads=%0d writes=%0d max_lat=%0d",
                 stat_rd_cnt, stat_wr_cnt, stat_max_lat);
    end
  end

  final begin
    $display("mem_port_monitor %m: reads=%0d writes=%0d max_lat=%0d last_addr=%h",
             stat_rd_cnt, stat_wr_cnt, stat_max_lat, out_q.addr);
  end
`endif

endmodule

// File: tb/tb_mem_port_monitor.sv
// Directed bench for mem_port_monitor with hand-computed expectations.
module tb_mem_port_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        valid;
  logic        write;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        protocol_error;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  mem_port_monitor #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .valid           (valid),
    .write           (write),
    .addr            (addr),
    .rdata           (rdata),
    .wmask           (wmask),
    .wdata           (wdata),
    .protocol_error  (protocol_error),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    mem_resp        = 1'b0;
    mem_rdata       = '0;
  endtask

  task automatic drive_read(input logic [31:0] a);
    mem_read    = 1'b1;
    mem_write   = 1'b0;
    mem_address = a;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    mem_read        = 1'b0;
    mem_write       = 1'b1;
    mem_address     = a;
    mem_byte_enable = m;
    mem_wdata       = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_write"}, 32'(write), 32'd0);
    chk({tag, "_addr"},  addr, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_wmask"}, 32'(wmask), 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
    chk({tag, "_perr"},  32'(protocol_error), 32'd0);
    chk({tag, "_tout"},  32'(timeout), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Read 0x60, response three cycles after the request is taken
    drive_read(32'h60);
    step();
    chk("rd_wait0_valid", 32'(valid), 32'd0);
    step();
    chk("rd_wait1_valid", 32'(valid), 32'd0);
    step();
    chk("rd_wait2_valid", 32'(valid), 32'd0);
    mem_resp  = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    step();
    chk("rd_valid", 32'(valid), 32'd1);
    chk("rd_write", 32'(write), 32'd0);
    chk("rd_addr", addr, 32'h60);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    bus_idle();
    step();
    chk("rd_pulse_end", 32'(valid), 32'd0);
    chk("rd_addr_hold", addr, 32'h60);
    chk("rd_rdata_hold", rdata, 32'hDEADBEEF);
    chk("rd_perr", 32'(protocol_error), 32'd0);
    chk("rd_tout", 32'(timeout), 32'd0);

    // Zero-wait write then back-to-back zero-wait read
    drive_write(32'h100, 4'b0011, 32'h12345678);
    mem_resp = 1'b1;
    step();
    chk("wr0_write", 32'(write), 32'd1);
    chk("wr0_valid", 32'(valid), 32'd0);
    chk("wr0_addr", addr, 32'h100);
    chk("wr0_wmask", 32'(wmask), 32'h3);
    chk("wr0_wdata", wdata, 32'h12345678);
    chk("wr0_rdata_keep", rdata, 32'hDEADBEEF);
    drive_read(32'h100);
    mem_resp  = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    step();
    chk("b2b_valid", 32'(valid), 32'd1);
    chk("b2b_write", 32'(write), 32'd0);
    chk("b2b_addr", addr, 32'h100);
    chk("b2b_rdata", rdata, 32'hCAFEF00D);
    chk("b2b_wmask_hold", 32'(wmask), 32'h3);
    chk("b2b_wdata_hold", wdata, 32'h12345678);
    bus_idle();
    step();
    chk("b2b_end_valid", 32'(valid), 32'd0);
    chk("b2b_perr", 32'(protocol_error), 32'd0);

    // Address changes while a read is pending
    drive_read(32'h40);
    step();
    chk("achg_perr_before", 32'(protocol_error), 32'd0);
    mem_address = 32'h44;
    step();
    chk("achg_perr", 32'(protocol_error), 32'd1);
    chk("achg_valid", 32'(valid), 32'd0);
    mem_resp  = 1'b1;
    mem_rdata = 32'h11112222;
    step();
    chk("achg_resp_valid", 32'(valid), 32'd1);
    chk("achg_resp_addr", addr, 32'h40);
    chk("achg_resp_rdata", rdata, 32'h11112222);
    bus_idle();
    step();
    chk("achg_perr_sticky", 32'(protocol_error), 32'd1);
    do_reset();
    chk("achg_perr_cleared", 32'(protocol_error), 32'd0);

    // Read and write together: flagged and handled as a read
    mem_read        = 1'b1;
    mem_write       = 1'b1;
    mem_address     = 32'h200;
    mem_byte_enable = 4'hF;
    mem_wdata       = 32'h77777777;
    mem_resp        = 1'b1;
    mem_rdata       = 32'hA5A5A5A5;
    step();
    chk("both_perr", 32'(protocol_error), 32'd1);
    chk("both_valid", 32'(valid), 32'd1);
    chk("both_write", 32'(write), 32'd0);
    chk("both_rdata", rdata, 32'hA5A5A5A5);
    do_reset();

    // Response on an idle bus
    mem_resp = 1'b1;
    step();
    chk("idle_resp_perr", 32'(protocol_error), 32'd1);
    chk("idle_resp_valid", 32'(valid), 32'd0);
    chk("idle_resp_write", 32'(write), 32'd0);
    do_reset();

    // Hung read: timeout after 8 pending cycles
    drive_read(32'h300);
    step();
    for (int i = 1; i <= 7; i++) step();
    chk("tout_at7", 32'(timeout), 32'd0);
    chk("tout_at7_valid", 32'(valid), 32'd0);
    step();
    chk("tout_at8", 32'(timeout), 32'd1);
    chk("tout_at8_valid", 32'(valid), 32'd0);
    chk("tout_perr", 32'(protocol_error), 32'd0);
    step();
    chk("tout_sticky", 32'(timeout), 32'd1);
    do_reset();
    chk("tout_cleared", 32'(timeout), 32'd0);

    // Reset during WR_PEND with a simultaneous response
    drive_read(32'h80);
    mem_resp  = 1'b1;
    mem_rdata = 32'h0BADF00D;
    step();
    chk("pre_rst_valid", 32'(valid), 32'd1);
    chk("pre_rst_rdata", rdata, 32'h0BADF00D);
    bus_idle();
    drive_write(32'h500, 4'hF, 32'h55AA55AA);
    step();
    rst      = 1'b1;
    mem_resp = 1'b1;
    step();
    chk_all_zero("rst_wr");
    rst = 1'b0;
    bus_idle();
    step();
    chk("rst_wr_no_pulse", 32'(write), 32'd0);
    chk("rst_wr_no_valid", 32'(valid), 32'd0);

    // Waited write leaves rdata untouched
    drive_read(32'h700);
    mem_resp  = 1'b1;
    mem_rdata = 32'h13579BDF;
    step();
    bus_idle();
    drive_write(32'h600, 4'b1100, 32'h9ABCDEF0);
    step();
    chk("wwr_wait0", 32'(write), 32'd0);
    step();
    chk("wwr_wait1", 32'(write), 32'd0);
    mem_resp = 1'b1;
    step();
    chk("wwr_write", 32'(write), 32'd1);
    chk("wwr_valid", 32'(valid), 32'd0);
    chk("wwr_addr", addr, 32'h600);
    chk("wwr_wmask", 32'(wmask), 32'hC);
    chk("wwr_wdata", wdata, 32'h9ABCDEF0);
    chk("wwr_rdata_keep", rdata, 32'h13579BDF);
    chk("wwr_perr", 32'(protocol_error), 32'd0);
    bus_idle();
    step();
    chk("wwr_pulse_end", 32'(write), 32'd0);

    // Request dropped before response
    drive_read(32'h800);
    step();
    bus_idle();
    step();
    chk("drop_perr", 32'(protocol_error), 32'd1);
    chk("drop_valid", 32'(valid), 32'd0);
    step();
    chk("drop_valid_late", 32'(valid), 32'd0);
    chk("drop_addr_hold", addr, 32'h600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
